// File: rtl/i2c_tx_sequencer.sv
// i2c_tx_sequencer: drives an I2C byte engine through START+address, FIFO data bytes and STOP; define I2C_SEQ_ADDR_RETRY_EN to retry a NACKed address up to 3 attempts
module i2c_tx_sequencer #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_req,
    input  logic [6:0]       slave_addr,
    input  logic [LEN_W-1:0] xfer_len,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data,
    output logic             fifo_rd,
    output logic             eng_valid,
    output logic [1:0]       eng_cmd,
    output logic [7:0]       eng_byte,
    input  logic             eng_ready,
    input  logic             eng_done,
    input  logic             eng_nack,
    output logic             busy,
    output logic             done,
    output logic             err_nack,
    output logic             err_underrun
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, WAIT_ADDR = 3'd2, FETCH = 3'd3,
                           DATA = 3'd4, WAIT_DATA = 3'd5, STOP = 3'd6, WAIT_STOP = 3'd7;
    logic [2:0]       state;
    logic [6:0]       addr;
    logic [LEN_W-1:0] remaining;
    logic [7:0]       data;
    logic [WW-1:0]    wait_cnt;
    logic             addr_retry;
`ifdef I2C_SEQ_ADDR_RETRY_EN
    logic [1:0] tries;
    // count address NACKs so the third one gives up instead of retrying
    always_ff @(posedge clk or negedge reset)
        if (!reset) tries <= '0;
        else if (state == IDLE) tries <= '0;
        else if (state == WAIT_ADDR && eng_done && eng_nack && addr_retry) tries <= tries + 2'd1;
    assign addr_retry = tries != 2'd2;
`else
    assign addr_retry = 1'b0;
`endif
    assign eng_valid = state == ADDR || state == DATA || state == STOP;
    assign eng_cmd   = state == DATA ? 2'b01 : state == STOP ? 2'b10 : 2'b00;
    assign eng_byte  = state == ADDR ? {addr, 1'b0} : state == DATA ? data : 8'h00;
    assign fifo_rd   = state == FETCH && !fifo_empty;
    assign busy      = state != IDLE;
    // count consecutive empty cycles spent in FETCH; any other state clears it
    always_ff @(posedge clk or negedge reset)
        if (!reset) wait_cnt <= '0;
        else wait_cnt <= (state == FETCH && fifo_empty) ? wait_cnt + 1'b1 : '0;
    // transfer sequencing, latched request fields and sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            addr         <= '0;
            remaining    <= '0;
            data         <= '0;
            done         <= 1'b0;
            err_nack     <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            done <= state == WAIT_STOP && eng_done;
            case (state)
                IDLE: if (start_req) begin
                    addr         <= slave_addr;
                    remaining    <= xfer_len;
                    err_nack     <= 1'b0;
                    err_underrun <= 1'b0;
                    state        <= ADDR;
                end
                ADDR: if (eng_ready) state <= WAIT_ADDR;
                WAIT_ADDR: if (eng_done) begin
                    if (eng_nack && addr_retry) state <= ADDR;
                    else if (eng_nack) begin
                        err_nack <= 1'b1;
                        state    <= STOP;
                    end else state <= remaining != '0 ? FETCH : STOP;
                end
                FETCH: if (!fifo_empty) begin
                    data  <= fifo_data;
                    state <= DATA;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                    err_underrun <= 1'b1;
                    state        <= STOP;
                end
                DATA: if (eng_ready) state <= WAIT_DATA;
                WAIT_DATA: if (eng_done) begin
                    if (remaining != '0) remaining <= remaining - 1'b1;
                    if (eng_nack) begin
                        err_nack <= 1'b1;
                        state    <= STOP;
                    end else state <= remaining <= LEN_W'(1) ? STOP : FETCH;
                end
                STOP: if (eng_ready) state <= WAIT_STOP;
                WAIT_STOP: if (eng_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/i2c_tx_sequencer.md
I2C_TX_SEQUENCER -- requirements
Module: i2c_tx_sequencer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  LEN_W 4 -- transfer-length width.
  TIMEOUT 255 -- maximum FIFO-empty wait, in cycles, per data byte.
REQ-002 SHALL have one clock and an asynchronous active-low reset, on ports as follows (name, direction, width, meaning):
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous reset, active low
  start_req  in  1  one-cycle request to begin a transfer
  slave_addr  in  7  7-bit target address; latched when start_req is accepted
  xfer_len  in  LEN_W  data-byte count; latched when start_req is accepted
  fifo_empty  in  1  TX FIFO empty flag
  fifo_data  in  8  TX FIFO head byte (combinational, valid while not empty)
  fifo_rd  out  1  one-cycle pop of the TX FIFO
  eng_valid  out  1  byte-engine command valid
  eng_cmd  out  2  00 = START+byte, 01 = byte, 10 = STOP
  eng_byte  out  8  byte to transmit
  eng_ready  in  1  engine accepts the command this cycle
  eng_done  in  1  one-cycle pulse: command finished on the bus
  eng_nack  in  1  NACK received; qualified by eng_done
  busy  out  1  transfer in progress
  done  out  1  one-cycle pulse at end of transfer
  err_nack  out  1  sticky: NACK occurred
  err_underrun  out  1  sticky: FIFO stayed empty past TIMEOUT

Function
REQ-003 FSM states SHALL be IDLE, ADDR, WAIT_ADDR, FETCH, DATA, WAIT_DATA, STOP, WAIT_STOP.
REQ-004 In IDLE, start_req SHALL latch slave_addr and xfer_len, clear err_nack and err_underrun, set busy, and go to ADDR; start_req SHALL be ignored in all other states.
REQ-005 In ADDR, the block SHALL drive eng_valid=1, eng_cmd=00, eng_byte={addr,1'b0}, hold them stable until eng_ready=1, then go to WAIT_ADDR.
REQ-006 In WAIT_ADDR, on eng_done: if eng_nack, set err_nack and go to STOP; else go to FETCH if the remaining count is nonzero, otherwise go to STOP.
REQ-007 In FETCH, if fifo_empty=0, the block SHALL capture fifo_data, pulse fifo_rd for exactly one cycle, and go to DATA.
REQ-008 In FETCH, if fifo_empty=1, a wait counter SHALL increment; on reaching TIMEOUT, set err_underrun, pop nothing, and go to STOP.
REQ-009 In DATA, the block SHALL drive eng_valid=1, eng_cmd=01, and the captured byte until eng_ready=1, then go to WAIT_DATA.
REQ-010 In WAIT_DATA, on eng_done the remaining count SHALL decrement; then:
  - eng_nack: set err_nack, go to STOP, with no further FIFO pops;
  - count now 0: go to STOP;
  - otherwise: go to FETCH.
REQ-011 In STOP, the block SHALL drive eng_valid=1, eng_cmd=10 until eng_ready=1, then go to WAIT_STOP.
REQ-012 In WAIT_STOP, on eng_done it SHALL pulse done for one cycle, clear busy, and return to IDLE.
REQ-013 eng_valid SHALL be 0 outside ADDR, DATA and STOP; eng_cmd and eng_byte SHALL NOT change while eng_valid=1 and eng_ready=0.
REQ-014 xfer_len=0 SHALL produce address then STOP, with zero FIFO pops.
REQ-015 The remaining count SHALL be LEN_W bits and SHALL never wrap below 0.
REQ-016 The wait counter SHALL clear on every entry to FETCH.
REQ-017 eng_done while eng_valid=1 SHALL be ignored.

Reset
REQ-018 Reset assertion SHALL immediately force IDLE, with all outputs 0 and all counters and latches 0, regardless of state.
REQ-019 Reset mid-transfer SHALL NOT issue STOP, and SHALL NOT touch FIFO contents.

Configuration
REQ-020 With I2C_SEQ_ADDR_RETRY_EN defined, an address NACK SHALL re-enter ADDR (repeated START), up to 3 attempts total; err_nack SHALL be set and STOP entered only after the 3rd NACK.
REQ-021 Without I2C_SEQ_ADDR_RETRY_EN, the first address NACK SHALL behave per REQ-006.

Verification
REQ-022 Benches SHALL cover the following directed scenarios:
  - addr=0x50, len=3, FIFO {A1,B2,C3}, engine always ACK -> cmds 00/A0, 01/A1, 01/B2, 01/C3, 10; 3 fifo_rd pulses; done=1, errors 0.
  - len=2, NACK on 1st data byte -> STOP follows; 1 fifo_rd; err_nack=1; done pulses.
  - len=1, FIFO empty for 300 cycles -> err_underrun=1 at cycle 255 of wait; STOP issued; 0 fifo_rd.
  - Address NACK always -> without macro: 1 address attempt; with macro: 3 cmd-00 attempts; then STOP, err_nack=1.
  - eng_ready held 0 for 10 cycles during DATA -> eng_byte stable; start_req pulsed mid-transfer ignored.
  - reset asserted in WAIT_DATA -> same cycle busy=0, eng_valid=0; next start_req runs cleanly.
